// File: rtl/ascon_params.sv
// Shared defaults and derived-width helpers for the serial-in capture path.
// Contents:
//   DEF_WORD_SIZE, DEF_PAR, DEF_D : default word width, bits per unmasked
//                                   beat, and masking order
//   k1, kd                        : beat widths for the narrow and wide modes
//   beats_1, beats_d              : beats needed to build one word in each mode
//   last_1, last_d                : width of the final beat in each mode
package ascon_params;

   localparam int DEF_WORD_SIZE = 64;
   localparam int DEF_PAR       = 1;
   localparam int DEF_D         = 1;

   // Narrow beat: one share of PAR bits.
   function automatic int k1(input int par);
      return par;
   endfunction

   // Wide beat: all D+1 shares at once.
   function automatic int kd(input int par, input int d);
      return (d + 1) * par;
   endfunction

   // A beat at least as wide as the word fills it in one go.
   function automatic int beats_of(input int ws, input int k);
      return (k >= ws) ? 1 : (ws + k - 1) / k;
   endfunction

   function automatic int last_of(input int ws, input int k);
      return ws - (beats_of(ws, k) - 1) * k;
   endfunction

   function automatic int beats_1(input int ws, input int par);
      return beats_of(ws, k1(par));
   endfunction

   function automatic int beats_d(input int ws, input int par, input int d);
      return beats_of(ws, kd(par, d));
   endfunction

   function automatic int last_1(input int ws, input int par);
      return last_of(ws, k1(par));
   endfunction

   function automatic int last_d(input int ws, input int par, input int d);
      return last_of(ws, kd(par, d));
   endfunction

endpackage

// File: rtl/debug_fifo.sv
// Word buffer behind the capture shifter.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   push, push_data       : write one word (ignored while full)
//   pop, pop_data         : head word and its removal strobe (ignored while empty)
//   full, empty, level    : occupancy, all derived from registered state
// DEPTH must be a power of two so the pointers wrap naturally.
module debug_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    level_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];
   assign level    = level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         // Push and pop together leave the level unchanged.
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: nothing is visible until a push moves the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/sipo_capture.sv
// Serial-in, parallel-out word capture.  Beats of K bits (K = PAR in mode 1,
// (D+1)*PAR in mode 0) are shifted in from the top until a full WORD_SIZE
// word is built; the finished word goes into a small FIFO.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   in_valid, in_ready           : beat handshake
//   in_mode, in_data             : beat width select (sampled on beat 0), payload
//   flush                        : abandon the partial word, drop this cycle's beat
//   out_data, out_valid, out_ready : head of the word FIFO
//   out_level                    : words held in the FIFO
//   word_count                   : completed words, saturating
// Handshakes: a transfer happens on a rising edge where valid && ready;
// in_ready depends only on registered FIFO occupancy.
module sipo_capture
   import ascon_params::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int PAR       = DEF_PAR,
   parameter int D         = DEF_D,
   parameter int DEPTH     = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_mode,
   input  logic [(D+1)*PAR-1:0]       in_data,
   input  logic                       flush,
   output logic [WORD_SIZE-1:0]       out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] out_level,
   output logic [15:0]                word_count
);

   localparam int K1      = k1(PAR);
   localparam int KD      = kd(PAR, D);
   localparam int BEATS_1 = beats_1(WORD_SIZE, PAR);
   localparam int BEATS_D = beats_d(WORD_SIZE, PAR, D);
   localparam int LAST_1  = last_1(WORD_SIZE, PAR);
   localparam int LAST_D  = last_d(WORD_SIZE, PAR, D);
   localparam int CW      = (BEATS_1 > 1) ? $clog2(BEATS_1) : 1;
   localparam int MAXW    = (KD > WORD_SIZE) ? KD : WORD_SIZE;

   logic [WORD_SIZE-1:0] state_q;
   logic [CW-1:0]        beat_cnt_q;
   logic                 mode_q;

   logic                 mode_cur;
   logic                 last_beat;
   int                   beats_cur;
   int                   sh;
   logic [MAXW-1:0]      din_ext;
   logic [WORD_SIZE-1:0] din_w;
   logic [WORD_SIZE-1:0] mask;
   logic [WORD_SIZE-1:0] state_nxt;
   logic                 accept;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign din_ext = MAXW'(in_data);

   // One shifter serves both modes: the incoming beat is trimmed to sh bits
   // and lands at the top while the old contents move down by sh.  A beat
   // that is as wide as the word (sh = WORD_SIZE) simply replaces it.
   always_comb begin
      mode_cur  = (beat_cnt_q == '0) ? in_mode : mode_q;
      beats_cur = mode_cur ? BEATS_1 : BEATS_D;
      last_beat = (int'(beat_cnt_q) == beats_cur - 1);
      if (mode_cur) sh = last_beat ? LAST_1 : K1;
      else          sh = last_beat ? LAST_D : KD;
      din_w     = din_ext[WORD_SIZE-1:0];
      mask      = ~({WORD_SIZE{1'b1}} << sh);
      state_nxt = (state_q >> sh) | ((din_w & mask) << (WORD_SIZE - sh));
   end

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;
   // Flush wins over a beat offered in the same cycle.
   assign accept    = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= '0;
         beat_cnt_q <= '0;
         mode_q     <= 1'b0;
         word_count <= '0;
      end else if (flush) begin
         state_q    <= '0;
         beat_cnt_q <= '0;
      end else if (accept) begin
         state_q <= state_nxt;
         mode_q  <= mode_cur;
         if (last_beat) begin
            beat_cnt_q <= '0;
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
         end else begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
         end
      end
   end

   // The finished word is pushed on the same edge as its last beat.
   debug_fifo #(
      .WIDTH(WORD_SIZE),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (accept && last_beat),
      .push_data(state_nxt),
      .pop      (out_ready),
      .pop_data (out_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (out_level)
   );

endmodule
